// File: rtl/bus_injector_pkg.sv
// Shared types and constants for the serial bus injector.
package bus_inj_pkg;

  localparam int BYTE_W = 8;

  localparam logic CKSUM_SUM = 1'b0;
  localparam logic CKSUM_XOR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WAIT_GAP,
    INJECT,
    DONE,
    HALT
  } state_t;

endpackage

// File: rtl/bus_injector_if.sv
// Serial bus pins seen by the injector: sampled input pair and driven output pair.
interface bus_injector_if;
  logic clk_in;
  logic data_in;
  logic clk_out;
  logic data_out;
  logic drive_en;

  modport master (input clk_in, data_in, output clk_out, data_out, drive_en);
  modport slave  (output clk_in, data_in, input clk_out, data_out, drive_en);
endinterface

// File: rtl/bus_injector_frame_checksum.sv
// Combinational 8-bit frame checksum: modulo-256 sum or XOR over NUM_BYTES bytes.
module frame_checksum
  import bus_inj_pkg::*;
#(
  parameter int NUM_BYTES = 4
)(
  input  logic [BYTE_W*NUM_BYTES-1:0] data,
  input  logic                        mode,
  output logic [BYTE_W-1:0]           cksum
);

  logic [BYTE_W-1:0] sum_acc;
  logic [BYTE_W-1:0] xor_acc;

  always_comb begin
    sum_acc = '0;
    xor_acc = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      sum_acc = sum_acc + data[i*BYTE_W +: BYTE_W];
      xor_acc = xor_acc ^ data[i*BYTE_W +: BYTE_W];
    end
    cksum = (mode == CKSUM_XOR) ? xor_acc : sum_acc;
  end

endmodule

// File: rtl/bus_injector.sv
// Captures a serial prefix off an external bus, then on the bus gap drives a
// programmable payload plus checksum back onto the bus pins.
module bus_injector
  import bus_inj_pkg::*;
#(
  parameter int PREFIX_BYTES  = 3,
  parameter int INJECT_BYTES  = 1,
  parameter int HALF_PERIOD   = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int IDLE_CYCLES   = 1024,
  parameter int OUT_LSB_FIRST = 1
)(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             oneshot,
  input  logic                             cksum_mode,
  bus_injector_if.master                   bus,
  input  logic [BYTE_W*INJECT_BYTES-1:0]   inject_data,
  output logic                             busy,
  output logic                             done,
  output logic [BYTE_W*PREFIX_BYTES-1:0]   prefix_data,
  output logic [15:0]                      inject_count
);

  localparam int CAP_BITS = BYTE_W*PREFIX_BYTES;
  localparam int TX_BITS  = BYTE_W*(INJECT_BYTES+1);
  localparam int CW       = $clog2(CAP_BITS+1);
  localparam int IW       = $clog2(TX_BITS);
  localparam int PW       = $clog2(2*HALF_PERIOD);
  localparam int TW       = $clog2(IDLE_CYCLES+1);

  localparam logic [CW-1:0] CAP_LAST = CW'(CAP_BITS-1);
  localparam logic [IW-1:0] TX_LAST  = IW'(TX_BITS-1);
  localparam logic [PW-1:0] PH_HALF  = PW'(HALF_PERIOD-1);
  localparam logic [PW-1:0] PH_LAST  = PW'(2*HALF_PERIOD-1);
  localparam logic [TW-1:0] IDLE_MAX = TW'(IDLE_CYCLES-1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  logic                   strobe, gap, s_dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= '0;
      dat_sync <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.clk_in};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus.data_in};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign s_dat  = dat_sync[SYNC_STAGES-1];
  assign strobe = clk_sync[SYNC_STAGES-1] & ~clk_prev;
  assign gap    = ~clk_sync[SYNC_STAGES-1] & ~s_dat;

  logic [BYTE_W-1:0]  cksum;
  logic [TX_BITS-1:0] next_frame;

  frame_checksum #(.NUM_BYTES(PREFIX_BYTES+INJECT_BYTES)) u_cksum (
    .data  ({prefix_data, inject_data}),
    .mode  (cksum_mode),
    .cksum (cksum)
  );

  // Checksum rides as the last byte; byte 0 of the payload goes out first.
  assign next_frame = {cksum, inject_data};

  function automatic logic [IW-1:0] bit_pos(input logic [IW-1:0] idx);
    return (OUT_LSB_FIRST != 0) ? idx : {idx[IW-1:3], ~idx[2:0]};
  endfunction

  state_t             state;
  logic [CW-1:0]      cap_cnt;
  logic [TW-1:0]      idle_cnt;
  logic [TX_BITS-1:0] tx_frame;
  logic [IW-1:0]      tx_idx;
  logic [PW-1:0]      ph_cnt;
  logic               clk_out_q, data_out_q, drive_en_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cap_cnt      <= '0;
      idle_cnt     <= '0;
      tx_frame     <= '0;
      tx_idx       <= '0;
      ph_cnt       <= '0;
      clk_out_q    <= 1'b0;
      data_out_q   <= 1'b0;
      drive_en_q   <= 1'b0;
      done         <= 1'b0;
      prefix_data  <= '0;
      inject_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cap_cnt  <= '0;
          idle_cnt <= '0;
          if (enable) state <= CAPTURE;
        end
        CAPTURE: begin
          if (!enable) begin
            state <= IDLE;
          end else if (strobe) begin
            prefix_data <= {prefix_data[CAP_BITS-2:0], s_dat};
            cap_cnt     <= cap_cnt + CW'(1);
            idle_cnt    <= '0;
            if (cap_cnt == CAP_LAST) state <= WAIT_GAP;
          end else if (idle_cnt == IDLE_MAX) begin
            // Bus stalled mid-frame: restart the byte alignment.
            cap_cnt  <= '0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        WAIT_GAP: begin
          if (!enable) begin
            state <= IDLE;
          end else if (gap) begin
            tx_frame   <= next_frame;
            tx_idx     <= '0;
            ph_cnt     <= '0;
            clk_out_q  <= 1'b1;
            data_out_q <= next_frame[bit_pos('0)];
            drive_en_q <= 1'b1;
            state      <= INJECT;
          end
        end
        INJECT: begin
          ph_cnt <= ph_cnt + PW'(1);
          if (ph_cnt == PH_HALF) clk_out_q <= 1'b0;
          if (ph_cnt == PH_LAST) begin
            ph_cnt <= '0;
            if (!enable || tx_idx == TX_LAST) begin
              clk_out_q  <= 1'b0;
              data_out_q <= 1'b0;
              drive_en_q <= 1'b0;
              if (!enable) begin
                state <= IDLE;
              end else begin
                state        <= DONE;
                done         <= 1'b1;
                inject_count <= inject_count + 16'd1;
              end
            end else begin
              tx_idx     <= tx_idx + IW'(1);
              clk_out_q  <= 1'b1;
              data_out_q <= tx_frame[bit_pos(tx_idx + IW'(1))];
            end
          end
        end
        DONE:    state <= oneshot ? HALT : IDLE;
        HALT:    if (!enable) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.clk_out  = clk_out_q;
  assign bus.data_out = data_out_q;
  assign bus.drive_en = drive_en_q;
  assign busy         = (state != IDLE);

endmodule
